// File: rtl/dcache_req_arbiter.sv
// Arbitrates the single dcache request port between the page-table walker and the LSU.
// PTW has priority; a saturating starvation counter forces an LSU grant after LSU_STARVE_MAX losses.
module dcache_req_arbiter #(
  parameter int unsigned PALEN          = 34,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned LSU_STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ptw_req_i,
  input  logic [PALEN-1:0]    ptw_paddr_i,
  output logic                ptw_ack_o,
  output logic [XLEN-1:0]     ptw_rdata_o,
  input  logic                lsu_req_i,
  input  logic [PALEN-1:0]    lsu_paddr_i,
  input  logic                lsu_we_i,
  input  logic [XLEN/8-1:0]   lsu_be_i,
  input  logic [XLEN-1:0]     lsu_wdata_i,
  output logic                lsu_ack_o,
  output logic [XLEN-1:0]     lsu_rdata_o,
  input  logic                flush_i,
  output logic                dcache_req_o,
  output logic [PALEN-1:0]    dcache_paddr_o,
  output logic                dcache_we_o,
  output logic [XLEN/8-1:0]   dcache_be_o,
  output logic [XLEN-1:0]     dcache_wdata_o,
  input  logic                dcache_ack_i,
  input  logic [XLEN-1:0]     dcache_rdata_i
);

  localparam int unsigned CntW = $clog2(LSU_STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(LSU_STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StPtwBusy, StLsuBusy, StDrain} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [PALEN-1:0]    paddr_q, paddr_d;
  logic                we_q, we_d;
  logic [XLEN/8-1:0]   be_q, be_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                lsu_starved;

  assign lsu_starved = lsu_req_i && (starve_cnt_q == StarveMax);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    paddr_d      = paddr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    ptw_ack_o    = 1'b0;
    lsu_ack_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!lsu_req_i) starve_cnt_d = '0;
        if (!flush_i) begin
          if (ptw_req_i && !lsu_starved) begin
            paddr_d = ptw_paddr_i;
            we_d    = 1'b0;
            be_d    = '1;
            wdata_d = '0;
            state_d = StPtwBusy;
            // Only counts grants the LSU actually lost; saturation is implied by lsu_starved
            if (lsu_req_i) starve_cnt_d = starve_cnt_q + 1'b1;
          end else if (lsu_req_i) begin
            paddr_d      = lsu_paddr_i;
            we_d         = lsu_we_i;
            be_d         = lsu_be_i;
            wdata_d      = lsu_wdata_i;
            state_d      = StLsuBusy;
            starve_cnt_d = '0;
          end
        end
      end
      StPtwBusy, StLsuBusy: begin
        if (dcache_ack_i) begin
          // A flush in the ack cycle swallows the response
          ptw_ack_o = !flush_i && (state_q == StPtwBusy);
          lsu_ack_o = !flush_i && (state_q == StLsuBusy);
          state_d   = StIdle;
        end else if (flush_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (dcache_ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      paddr_q      <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      paddr_q      <= paddr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
    end
  end

  assign dcache_req_o   = (state_q != StIdle);
  assign dcache_paddr_o = paddr_q;
  assign dcache_we_o    = we_q;
  assign dcache_be_o    = be_q;
  assign dcache_wdata_o = wdata_q;
  assign ptw_rdata_o    = ptw_ack_o ? dcache_rdata_i : '0;
  assign lsu_rdata_o    = lsu_ack_o ? dcache_rdata_i : '0;

  // The owner must hold its request until acked unless a flush abandons it
  ptw_req_held_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StPtwBusy && !flush_i) |-> ptw_req_i);
  lsu_req_held_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StLsuBusy && !flush_i) |-> lsu_req_i);

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Randomized scoreboard bench for dcache_req_arbiter: a transaction-level reference model
// predicts grants and acks; a decoupled monitor pops and compares what the DUT presents.
module tb_dcache_req_arbiter;

  localparam int PALEN = 34;
  localparam int XLEN  = 32;
  localparam int BEW   = XLEN / 8;
  localparam int SMAX  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ptw_req, ptw_ack, lsu_req, lsu_we, lsu_ack, flush;
  logic [PALEN-1:0] ptw_paddr, lsu_paddr, dc_paddr;
  logic [XLEN-1:0]  ptw_rdata, lsu_wdata, lsu_rdata, dc_wdata, dc_rdata;
  logic [BEW-1:0]   lsu_be, dc_be;
  logic             dc_req, dc_we, dc_ack;

  dcache_req_arbiter #(.PALEN(PALEN), .XLEN(XLEN), .LSU_STARVE_MAX(SMAX)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ptw_req_i     (ptw_req),
    .ptw_paddr_i   (ptw_paddr),
    .ptw_ack_o     (ptw_ack),
    .ptw_rdata_o   (ptw_rdata),
    .lsu_req_i     (lsu_req),
    .lsu_paddr_i   (lsu_paddr),
    .lsu_we_i      (lsu_we),
    .lsu_be_i      (lsu_be),
    .lsu_wdata_i   (lsu_wdata),
    .lsu_ack_o     (lsu_ack),
    .lsu_rdata_o   (lsu_rdata),
    .flush_i       (flush),
    .dcache_req_o  (dc_req),
    .dcache_paddr_o(dc_paddr),
    .dcache_we_o   (dc_we),
    .dcache_be_o   (dc_be),
    .dcache_wdata_o(dc_wdata),
    .dcache_ack_i  (dc_ack),
    .dcache_rdata_i(dc_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PALEN-1:0] paddr;
    logic             we;
    logic [BEW-1:0]   be;
    logic [XLEN-1:0]  wdata;
    bit               is_lsu;
  } txn_t;

  typedef struct {
    bit              is_lsu;
    logic [XLEN-1:0] rdata;
  } ack_t;

  txn_t exp_txn_q[$];
  ack_t exp_ack_q[$];
  bit   exp_req;
  int   checks = 0;
  int   failures = 0;

  // Reference model: who holds the dcache (0 nobody, 1 PTW, 2 LSU, 3 abandoned), how many
  // grants in a row the waiting LSU has lost, and the remaining dcache latency.
  int   m_owner, passed_over, lat;
  bit   ptw_release, lsu_release;
  int   req_pct, flush_pct;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=no_event", name);
  endtask

  task automatic release_owner();
    if (m_owner == 1) ptw_release = 1'b1;
    if (m_owner == 2) lsu_release = 1'b1;
  endtask

  task automatic model_reset();
    m_owner = 0; passed_over = 0; lat = 0;
    ptw_release = 1'b0; lsu_release = 1'b0;
    exp_txn_q.delete(); exp_ack_q.delete();
    exp_req = 1'b0;
  endtask

  // Called once per cycle at the falling edge: drives this cycle's inputs and advances the model
  task automatic drive_cycle();
    txn_t t;
    ack_t a;
    if (ptw_release) begin ptw_req = 1'b0; ptw_release = 1'b0; end
    if (lsu_release) begin lsu_req = 1'b0; lsu_release = 1'b0; end
    if (!ptw_req && $urandom_range(99) < req_pct) begin
      ptw_req   = 1'b1;
      ptw_paddr = PALEN'({$urandom(), $urandom()});
    end
    if (!lsu_req && $urandom_range(99) < req_pct) begin
      lsu_req   = 1'b1;
      lsu_paddr = PALEN'({$urandom(), $urandom()});
      lsu_we    = 1'($urandom());
      lsu_be    = BEW'($urandom());
      lsu_wdata = $urandom();
    end
    flush    = ($urandom_range(99) < flush_pct);
    dc_ack   = (m_owner != 0) && (lat == 0);
    dc_rdata = $urandom();
    exp_req  = (m_owner != 0);

    case (m_owner)
      0: begin
        bit starved;
        starved = lsu_req && (passed_over >= SMAX);
        if (!lsu_req) passed_over = 0;
        if (!flush) begin
          if (ptw_req && !starved) begin
            t = '{paddr: ptw_paddr, we: 1'b0, be: '1, wdata: '0, is_lsu: 1'b0};
            exp_txn_q.push_back(t);
            if (lsu_req && passed_over < SMAX) passed_over++;
            m_owner = 1;
            lat = $urandom_range(3);
          end else if (lsu_req) begin
            t = '{paddr: lsu_paddr, we: lsu_we, be: lsu_be, wdata: lsu_wdata, is_lsu: 1'b1};
            exp_txn_q.push_back(t);
            passed_over = 0;
            m_owner = 2;
            lat = $urandom_range(3);
          end
        end
      end
      1, 2: begin
        if (dc_ack) begin
          if (!flush) begin
            a = '{is_lsu: (m_owner == 2), rdata: dc_rdata};
            exp_ack_q.push_back(a);
          end
          release_owner();
          m_owner = 0;
        end else begin
          lat--;
          if (flush) begin
            release_owner();
            m_owner = 3;
          end
        end
      end
      default: begin
        if (dc_ack) m_owner = 0;
        else lat--;
      end
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},       dc_req,    '0);
    check({tag, "_paddr"},     dc_paddr,  '0);
    check({tag, "_we"},        dc_we,     '0);
    check({tag, "_be"},        dc_be,     '0);
    check({tag, "_wdata"},     dc_wdata,  '0);
    check({tag, "_ptw_ack"},   ptw_ack,   '0);
    check({tag, "_lsu_ack"},   lsu_ack,   '0);
    check({tag, "_ptw_rdata"}, ptw_rdata, '0);
    check({tag, "_lsu_rdata"}, lsu_rdata, '0);
  endtask

  // Async reset in the middle of a PTW transaction, with dcache ack/rdata deliberately live
  task automatic reset_mid_busy();
    rst_n    = 1'b0;
    ptw_req  = 1'b0;
    lsu_req  = 1'b0;
    flush    = 1'b0;
    dc_ack   = 1'b1;
    dc_rdata = 32'hDEAD_BEEF;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    dc_ack = 1'b0;
    rst_n  = 1'b1;
  endtask

  // Monitor: samples shortly before each rising edge and pops the scoreboard queues
  bit prev_req = 1'b0;
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      txn_t t;
      ack_t a;
      check("dcache_req", dc_req, exp_req);
      if (dc_req && !prev_req) begin
        if (exp_txn_q.size() == 0) begin
          flag("unexpected_grant");
        end else begin
          t = exp_txn_q.pop_front();
          check("grant_paddr", dc_paddr, t.paddr);
          check("grant_we",    dc_we,    t.we);
          check("grant_be",    dc_be,    t.be);
          if (t.is_lsu) check("grant_wdata", dc_wdata, t.wdata);
        end
      end
      prev_req = dc_req;
      if (ptw_ack && lsu_ack) flag("both_acks");
      if (ptw_ack || lsu_ack) begin
        if (exp_ack_q.size() == 0) begin
          flag(ptw_ack ? "spurious_ptw_ack" : "spurious_lsu_ack");
        end else begin
          a = exp_ack_q.pop_front();
          check("ack_is_lsu", lsu_ack, a.is_lsu);
          check("ack_rdata", lsu_ack ? lsu_rdata : ptw_rdata, a.rdata);
        end
      end else if (exp_ack_q.size() != 0) begin
        a = exp_ack_q.pop_front();
        check("missing_ack", {ptw_ack, lsu_ack}, a.is_lsu ? 2'b01 : 2'b10);
      end
      if (!ptw_ack) check("ptw_rdata_zero", ptw_rdata, '0);
      if (!lsu_ack) check("lsu_rdata_zero", lsu_rdata, '0);
    end
  end

  task automatic run(input int cycles, input int rpct, input int fpct);
    req_pct = rpct;
    flush_pct = fpct;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      drive_cycle();
    end
  endtask

  initial begin
    ptw_req = 1'b0; ptw_paddr = '0; lsu_req = 1'b0; lsu_paddr = '0; lsu_we = 1'b0;
    lsu_be = '0; lsu_wdata = '0; flush = 1'b0; dc_ack = 1'b0; dc_rdata = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(600, 30, 5);    // sparse mixed traffic
    run(300, 100, 0);   // both requesters saturate: exercises the starvation limit
    run(400, 50, 25);   // heavy flushing in IDLE, BUSY and DRAIN

    for (int r = 0; r < 3; r++) begin
      bit hit;
      hit = 1'b0;
      req_pct = 60;
      flush_pct = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(negedge clk);
        if (m_owner == 1) begin
          reset_mid_busy();
          hit = 1'b1;
        end
        drive_cycle();
      end
      if (!hit) flag("reset_window_timeout");
      run(60, 40, 5);
    end

    run(40, 0, 0);      // let everything drain
    check("leftover_txns", exp_txn_q.size(), 0);
    check("leftover_acks", exp_ack_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
